// File: rtl/sram_l1_ctrl_pkg.sv
// Shared types and constants for the L1 SRAM port arbiter: FSM state encoding,
// default bus widths and the active-low SRAM control levels.
package sram_l1_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WR_HOLD = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_e;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_MASK_W = 8;

  // SRAM control pins are active low.
  localparam logic CSB_ON   = 1'b0;
  localparam logic CSB_OFF  = 1'b1;
  localparam logic WE_WRITE = 1'b0;
  localparam logic WE_READ  = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_l1_port_arbiter_if.sv
// Requester-side bus of the L1 SRAM port arbiter: packed per-requester
// request payloads, one-hot handshake and the shared response channel.
interface sram_l1_port_arbiter_if
  import sram_l1_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MASK_W = DEF_MASK_W
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ*MASK_W-1:0] req_wmask;

  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;

  // Requesters drive the request payload and observe handshake/response.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/sram_l1_rr_arbiter.sv
// Round-robin grant generator: one-hot grant from the request vector, search
// starting at the pointer, pointer advanced past the winner on accept.
module sram_l1_rr_arbiter #(
  parameter  int NREQ  = 2,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             accept,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W:0]   cand;
  logic             found;

  // Walk the requesters in rotated order; the first asserted one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr_reg} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                   = 1'b1;
        grant[cand[IDX_W-1:0]]  = 1'b1;
        grant_idx               = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (accept) begin
      ptr_next = (grant_idx == IDX_W'(NREQ-1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/sram_l1_port_arbiter.sv
// Shares one L1 SRAM wrapper between NREQ requesters: round-robin accept,
// active-low csb/we sequencing, variable read latency with timeout, 1-cycle response.
module sram_l1_port_arbiter
  import sram_l1_ctrl_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MASK_W    = DEF_MASK_W,
  parameter int WR_CYCLES = 2,
  parameter int TIMEOUT   = 80
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_l1_port_arbiter_if.slave req_if,
  output logic                  sram_csb,
  output logic                  sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  output logic [MASK_W-1:0]     sram_wmask,
  input  logic [DATA_W-1:0]     sram_rdata,
  input  logic                  sram_ready
);

  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = max_int(TIMEOUT, WR_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state_reg, state_next;
  logic              we_reg, we_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              csb_reg, csb_next;
  logic              swe_reg, swe_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [MASK_W-1:0] wmask_reg, wmask_next;
  logic [NREQ-1:0]   rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;

  logic [NREQ-1:0]   arb_req;
  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              accept;

  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];
  logic [MASK_W-1:0] wmask_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_if.req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_if.req_wdata[gi*DATA_W +: DATA_W];
      assign wmask_arr[gi] = req_if.req_wmask[gi*MASK_W +: MASK_W];
    end
  endgenerate

  // Requests are only visible to the arbiter while idle and out of reset,
  // so req_ready can never overlap a busy state or a response.
  assign arb_req = (state_reg == IDLE && !rst) ? req_if.req_valid : '0;
  assign accept  = |grant;

  sram_l1_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_next     = state_reg;
    we_next        = we_reg;
    idx_next       = idx_reg;
    cnt_next       = cnt_reg;
    csb_next       = csb_reg;
    swe_next       = swe_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wmask_next     = wmask_reg;
    rsp_valid_next = '0;
    rdata_next     = rdata_reg;
    err_next       = err_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          we_next    = req_if.req_we[grant_idx];
          idx_next   = grant_idx;
          addr_next  = addr_arr[grant_idx];
          wdata_next = wdata_arr[grant_idx];
          wmask_next = wmask_arr[grant_idx];
          swe_next   = req_if.req_we[grant_idx] ? WE_WRITE : WE_READ;
          csb_next   = CSB_OFF;
          state_next = SETUP;
        end
      end

      SETUP: begin
        csb_next   = CSB_ON;
        cnt_next   = CNT_W'(1);
        state_next = we_reg ? WR_HOLD : RD_WAIT;
      end

      WR_HOLD: begin
        if (cnt_reg >= CNT_W'(WR_CYCLES)) begin
          csb_next                = CSB_OFF;
          swe_next                = WE_READ;
          err_next                = 1'b0;
          rsp_valid_next[idx_reg] = 1'b1;
          state_next              = RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      RD_WAIT: begin
        // Data beats the timeout when both land on the same cycle.
        if (sram_ready) begin
          rdata_next              = sram_rdata;
          err_next                = 1'b0;
          csb_next                = CSB_OFF;
          swe_next                = WE_READ;
          rsp_valid_next[idx_reg] = 1'b1;
          state_next              = RESP;
        end else if (cnt_reg >= CNT_W'(TIMEOUT)) begin
          rdata_next              = '0;
          err_next                = 1'b1;
          csb_next                = CSB_OFF;
          swe_next                = WE_READ;
          rsp_valid_next[idx_reg] = 1'b1;
          state_next              = RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      RESP: begin
        csb_next   = CSB_OFF;
        swe_next   = WE_READ;
        state_next = IDLE;
      end

      default: begin
        csb_next   = CSB_OFF;
        swe_next   = WE_READ;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      csb_reg       <= CSB_OFF;
      swe_reg       <= WE_READ;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wmask_reg     <= '0;
      rsp_valid_reg <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      we_reg        <= we_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      csb_reg       <= csb_next;
      swe_reg       <= swe_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wmask_reg     <= wmask_next;
      rsp_valid_reg <= rsp_valid_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
    end
  end

  assign req_if.req_ready = grant;
  assign req_if.rsp_valid = rsp_valid_reg;
  assign req_if.rsp_rdata = rdata_reg;
  assign req_if.rsp_err   = err_reg;

  assign sram_csb   = csb_reg;
  assign sram_we    = swe_reg;
  assign sram_addr  = addr_reg;
  assign sram_wdata = wdata_reg;
  assign sram_wmask = wmask_reg;

endmodule

// File: tb/tb_sram_l1_port_arbiter.sv
// Self-checking bench for sram_l1_port_arbiter: behavioural SRAM with selectable
// read latency, expected memory image and round-robin model kept in the bench.
module tb_sram_l1_port_arbiter;

  localparam int NREQ      = 2;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 64;
  localparam int MASK_W    = 8;
  localparam int WR_CYCLES = 2;
  localparam int TIMEOUT   = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_l1_port_arbiter_if #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)
  ) bus ();

  logic              sram_csb;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic              sram_ready = 1'b0;

  sram_l1_port_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
    .WR_CYCLES(WR_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_if     (bus),
    .sram_csb   (sram_csb),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_wmask (sram_wmask),
    .sram_rdata (sram_rdata),
    .sram_ready (sram_ready)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural SRAM: answers a read in its rd_lat-th csb-low cycle (0 = never),
  // and throws random ready/data at the controller whenever no read is pending.
  bit [DATA_W-1:0] sram_mem [2**ADDR_W];
  int low_cnt = 0;
  int rd_lat  = 0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      low_cnt    = 0;
      sram_ready = 1'b0;
    end else begin
      if (sram_csb == 1'b0) low_cnt++;
      else low_cnt = 0;
      if (sram_csb == 1'b0 && sram_we == 1'b0) begin
        for (int b = 0; b < MASK_W; b++)
          if (sram_wmask[b]) sram_mem[sram_addr][b*8 +: 8] = sram_wdata[b*8 +: 8];
      end
      if (sram_csb == 1'b0 && sram_we == 1'b1) begin
        sram_ready = (low_cnt == rd_lat);
        sram_rdata = sram_ready ? sram_mem[sram_addr] : {$urandom, $urandom};
      end else begin
        sram_ready = 1'($urandom_range(0, 1));
        sram_rdata = {$urandom, $urandom};
      end
    end
  end

  // Bench-side view of the requesters and the expected memory contents.
  bit [DATA_W-1:0]   exp_mem [2**ADDR_W];
  int                remain  [NREQ];
  logic              p_we    [NREQ];
  logic [ADDR_W-1:0] p_addr  [NREQ];
  logic [DATA_W-1:0] p_wdata [NREQ];
  logic [MASK_W-1:0] p_wmask [NREQ];
  int                last_grant = NREQ - 1;
  int                gen_mode   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_payload(input int i);
    p_we[i]    = (gen_mode == 2) ? 1'($urandom_range(0, 1)) : (gen_mode == 1);
    p_addr[i]  = ADDR_W'($urandom_range(40, 55));
    p_wdata[i] = {$urandom, $urandom};
    p_wmask[i] = MASK_W'($urandom);
  endtask

  task automatic drive_bus();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]                   = (remain[i] > 0);
      bus.req_we[i]                      = p_we[i];
      bus.req_addr[i*ADDR_W +: ADDR_W]   = p_addr[i];
      bus.req_wdata[i*DATA_W +: DATA_W]  = p_wdata[i];
      bus.req_wmask[i*MASK_W +: MASK_W]  = p_wmask[i];
    end
  endtask

  task automatic wait_accept(output bit ok);
    int waited = 0;
    #1;
    while (bus.req_ready == '0 && waited < 10) begin
      @(negedge clk); #1;
      waited++;
    end
    ok = (bus.req_ready != '0);
    chk("accept_wait", {63'd0, ok}, 64'd1);
  endtask

  // Serves one transaction: checks the round-robin winner, the csb/we window,
  // the busy-time handshake and the response cycle against the timing rules.
  task automatic serve(input int lat_sel);
    int exp_win = -1;
    int lat = 0, rsp_c, last_low;
    bit ok;
    logic exp_we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] exp_rd = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int j = (last_grant + k) % NREQ;
      if (exp_win < 0 && remain[j] > 0) exp_win = j;
    end
    drive_bus();
    wait_accept(ok);
    if (!ok) return;
    chk("grant", 64'(bus.req_ready), 64'(1) << exp_win);
    exp_we = p_we[exp_win];
    a      = p_addr[exp_win];
    if (exp_we) begin
      for (int b = 0; b < MASK_W; b++)
        if (p_wmask[exp_win][b]) exp_mem[a][b*8 +: 8] = p_wdata[exp_win][b*8 +: 8];
      last_low = 1 + WR_CYCLES;
    end else begin
      lat      = (lat_sel >= 0) ? lat_sel : $urandom_range(1, 10);
      exp_rd   = (lat == 0) ? '0 : exp_mem[a];
      last_low = 1 + ((lat == 0) ? TIMEOUT : lat);
    end
    rsp_c = last_low + 1;
    $display("txn req=%0d we=%0d addr=%0d lat=%0d rsp_cycle=%0d", exp_win, exp_we, a, lat, rsp_c);
    remain[exp_win]--;
    last_grant = exp_win;
    if (remain[exp_win] > 0) new_payload(exp_win);
    @(posedge clk);
    rd_lat = lat;
    for (int c = 1; c <= rsp_c; c++) begin
      @(negedge clk);
      chk("csb", {63'd0, sram_csb}, (c >= 2 && c <= last_low) ? 64'd0 : 64'd1);
      if (c >= 2 && c <= last_low) chk("we", {63'd0, sram_we}, exp_we ? 64'd0 : 64'd1);
      if (c == 2) chk("addr", 64'(sram_addr), 64'(a));
      chk("ready_busy", 64'(bus.req_ready), 64'd0);
      if (c < rsp_c) begin
        chk("rsp_early", 64'(bus.rsp_valid), 64'd0);
      end else begin
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(1) << exp_win);
        chk("rsp_err", {63'd0, bus.rsp_err}, (!exp_we && lat == 0) ? 64'd1 : 64'd0);
        if (!exp_we) chk("rsp_rdata", bus.rsp_rdata, exp_rd);
      end
      if (c == 1) drive_bus();
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) remain[i] = 0;
  endtask

  task automatic rand_bus();
    bus.req_valid = NREQ'($urandom);
    bus.req_we    = NREQ'($urandom);
    bus.req_addr  = {NREQ{ADDR_W'($urandom)}};
    bus.req_wdata = {NREQ{$urandom, $urandom}};
    bus.req_wmask = {NREQ{MASK_W'($urandom)}};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int i = 0; i < NREQ; i++) begin
      remain[i] = 0; p_we[i] = 0; p_addr[i] = '0; p_wdata[i] = '0; p_wmask[i] = '0;
    end
    rand_bus();
    // Reset held for two cycles under random request traffic.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_csb", {63'd0, sram_csb}, 64'd1);
      chk("rst_we", {63'd0, sram_we}, 64'd1);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_rsp", 64'(bus.rsp_valid), 64'd0);
      rand_bus();
    end
    rst = 1'b0;
    clear_reqs();
    drive_bus();

    // Directed write then read-back with a 6-cycle read latency.
    remain[0] = 1; p_we[0] = 1'b1; p_addr[0] = 11'd48; p_wdata[0] = 64'd77; p_wmask[0] = 8'hFF;
    serve(-1);
    remain[0] = 1; p_we[0] = 1'b0; p_addr[0] = 11'd48;
    serve(6);

    // Random single-requester mix of writes and reads.
    gen_mode = 2;
    for (int n = 0; n < 14; n++) begin
      int i = $urandom_range(0, NREQ - 1);
      remain[i] = 1;
      new_payload(i);
      serve(-1);
    end

    // Both requesters contend with four reads each.
    gen_mode = 0;
    for (int i = 0; i < NREQ; i++) begin
      remain[i] = 4;
      new_payload(i);
    end
    for (int n = 0; n < 4 * NREQ; n++) serve(-1);

    // Hung SRAM: timeout, then a normal read.
    remain[1] = 1; p_we[1] = 1'b0; p_addr[1] = 11'd50;
    serve(0);
    remain[0] = 1; new_payload(0);
    serve(-1);

    // Reset in the third RD_WAIT cycle of a read that never completes.
    remain[0] = 1; p_we[0] = 1'b0; p_addr[0] = 11'd44;
    rd_lat = 0;
    drive_bus();
    wait_accept(ok);
    @(posedge clk);
    remain[0] = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) drive_bus();
    end
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_csb", {63'd0, sram_csb}, 64'd1);
    chk("mid_rst_we", {63'd0, sram_we}, 64'd1);
    chk("mid_rst_rsp", 64'(bus.rsp_valid), 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("mid_rst_rsp_hold", 64'(bus.rsp_valid), 64'd0);
      chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    end
    rst = 1'b0;
    last_grant = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      remain[i] = 1;
      new_payload(i);
    end
    for (int n = 0; n < NREQ; n++) serve(-1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
